gecko_load_writeback: RTL
=========================

// Module: gecko_load_writeback
// PURPOSE
//  Memory-response stage of the gecko core, downstream of execute. Execute issues a load request
//  to data memory and, in the same cycle, pushes its gecko_mem_operation_t here. This block keeps
//  the ops of outstanding loads in an in-order pending FIFO. It pairs each memory response with the
//  oldest pending op, and applies gecko_get_load_result (byte/half extract, sign/zero extension).
//  It emits a registered gecko_operation_t towards the register-file writeback.
// PARAMETERS
//  PENDING_DEPTH  4  max outstanding loads; power of two, >=2
// PORTS
//  clk                 in   1    clock, all state on rising edge
//  rst                 in   1    asynchronous, active-low reset
//  mem_command_valid   in   1    execute presents a load op
//  mem_command_ready   out  1    pending FIFO not full
//  mem_command         in   13   gecko_mem_operation_t {addr, reg_status, op, offset}
//  mem_result_valid    in   1    data memory response valid (in request order)
//  mem_result_ready    out  1    block can consume response
//  mem_result_data     in   32   raw 32-bit word read from memory
//  writeback_valid     out  1    result op valid
//  writeback_ready     in   1    writeback stage accepts
//  writeback_op        out  41   gecko_operation_t {addr, reg_status, speculative, value}
//  pending_count       out  $clog2(PENDING_DEPTH+1)  occupancy of pending FIFO
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO pointers/count=0, writeback_valid=0, writeback_op=0;
//    mem_command_ready=1 and mem_result_ready=0 after reset; all in-flight ops discarded.
//  - Pending FIFO: push on mem_command_valid&&mem_command_ready; mem_command_ready = (count!=DEPTH),
//    depends on registered count only. Pointers wrap modulo PENDING_DEPTH. No drop, no reorder.
//  - mem_result_ready = (count!=0) && (!writeback_valid || writeback_ready). No bypass: an op pushed
//    in cycle N can match a response no earlier than cycle N+1.
//  - Result handshake in cycle N pops FIFO head. In cycle N+1: writeback_valid=1 and
//    writeback_op = {head.addr, head.reg_status, speculative=0, load_result(data, head.offset, head.op)}.
//  - Load result by funct3: LB 000 sign-ext byte at offset; LH 001 sign-ext half at offset[1];
//    LW 010 full word; LBU 100 zero-ext byte; LHU 101 zero-ext half; other codes -> LW behaviour.
//  - Output register: holds value and valid while writeback_valid && !writeback_ready. Cleared to
//    valid=0 on writeback handshake unless a new result is accepted in the same cycle. Back-to-back
//    operation: one op per cycle at full throughput.
//  - Simultaneous push+pop: count unchanged, both pointers advance. Push when full is impossible
//    (ready low). Pop when empty is impossible (ready low).
//  - mem_result_valid while count==0: protocol violation, not consumed; simulation assertion fires.
//  - pending_count = registered count, updated the cycle after each push/pop.
// CONFIGURATION
//  GECKO_LOAD_WRITEBACK_FORWARD_EN: when defined, adds output port
//    writeback_forward  out  42  gecko_forwarded_t = gecko_construct_forward(writeback_valid, writeback_op)
//  This port gives decode early forwarding of the load value before register-file writeback.
//  When undefined, the port is absent and the logic is removed. Core behaviour is identical either way.
// TESTING
//  1. LW: cmd{addr=5,op=010,offset=0}, data 0xDEADBEEF -> next cycle op{addr=5,value=0xDEADBEEF,spec=0}.
//  2. LB offset 3, data 0x80FF1234 -> value 0xFFFFFF80. LBU offset 1, data 0x0000A500 -> 0x000000A5.
//  3. LH offset 2, data 0x8001_0000 -> 0xFFFF8001. LHU offset 2, same data -> 0x00008001.
//  4. Push 4 cmds, no responses -> mem_command_ready=0, pending_count=4. One response -> ready=1 next cycle.
//     Then 4 responses in order -> the 4 ops come out in push order with matching rd addr.
//  5. writeback_ready=0 with output valid -> writeback_op stable, mem_result_ready=0.
//     Release -> back-to-back drain at 1 op/cycle.
//  6. Assert rst with 3 pending and output valid -> writeback_valid=0, pending_count=0 immediately.
//     After release, a new LW completes normally.
//  7. (FORWARD_EN) Output op addr=7 valid -> writeback_forward={addr=7,valid=1,spec=0,value equal}.

Source files
------------

// File: rtl/gecko_load_writeback.sv
// gecko_load_writeback: pairs in-order data-memory responses with pending load ops and registers
// the extracted load result for writeback. Optional feature macro: GECKO_LOAD_WRITEBACK_FORWARD_EN.
module gecko_load_writeback #(
    parameter int PENDING_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               mem_command_valid,
    output logic                               mem_command_ready,
    input  logic [12:0]                        mem_command,
    input  logic                               mem_result_valid,
    output logic                               mem_result_ready,
    input  logic [31:0]                        mem_result_data,
    output logic                               writeback_valid,
    input  logic                               writeback_ready,
    output logic [40:0]                        writeback_op,
    output logic [$clog2(PENDING_DEPTH+1)-1:0] pending_count
`ifdef GECKO_LOAD_WRITEBACK_FORWARD_EN
    ,
    output logic [41:0]                        writeback_forward
`endif
);
    localparam int PTR_W = $clog2(PENDING_DEPTH);
    localparam int CNT_W = $clog2(PENDING_DEPTH + 1);

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_e;

    typedef struct packed {
        logic [4:0] addr;
        logic [2:0] reg_status;
        logic [2:0] op;
        logic [1:0] offset;
    } mem_op_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [2:0]  reg_status;
        logic        speculative;
        logic [31:0] value;
    } op_t;

    function automatic logic [31:0] load_result(input logic [31:0] data,
                                                input logic [1:0]  offset,
                                                input logic [2:0]  f3);
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        sel_byte = data[{offset, 3'b000} +: 8];
        sel_half = offset[1] ? data[31:16] : data[15:0];
        case (f3)
            F3_LB:   return {{24{sel_byte[7]}}, sel_byte};
            F3_LH:   return {{16{sel_half[15]}}, sel_half};
            F3_LBU:  return {24'd0, sel_byte};
            F3_LHU:  return {16'd0, sel_half};
            default: return data;  // LW and every unassigned code
        endcase
    endfunction

    mem_op_t            r_mem [PENDING_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_wb_valid;
    op_t                r_wb_op;

    logic               w_push;
    logic               w_pop;
    mem_op_t            w_head;
    op_t                w_result;

    assign mem_command_ready = (r_count != CNT_W'(PENDING_DEPTH));
    assign mem_result_ready  = (r_count != '0) && (!r_wb_valid || writeback_ready);
    assign w_push            = mem_command_valid && mem_command_ready;
    assign w_pop             = mem_result_valid && mem_result_ready;

    assign w_head               = r_mem[r_rd_ptr];
    assign w_result.addr        = w_head.addr;
    assign w_result.reg_status  = w_head.reg_status;
    assign w_result.speculative = 1'b0;
    assign w_result.value       = load_result(mem_result_data, w_head.offset, w_head.op);

    // NOTE: the op storage has no reset; only pointers and count say which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= mem_operation_cast(mem_command);
    end

    function automatic mem_op_t mem_operation_cast(input logic [12:0] raw);
        return mem_op_t'(raw);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A new result may replace the current one in the same cycle it is handed off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb_op    <= '0;
        end else if (w_pop) begin
            r_wb_valid <= 1'b1;
            r_wb_op    <= w_result;
        end else if (writeback_ready) begin
            r_wb_valid <= 1'b0;
        end
    end

    assign writeback_valid = r_wb_valid;
    assign writeback_op    = r_wb_op;
    assign pending_count   = r_count;

`ifdef GECKO_LOAD_WRITEBACK_FORWARD_EN
    typedef struct packed {
        logic [4:0]  addr;
        logic [2:0]  reg_status;
        logic        valid;
        logic        speculative;
        logic [31:0] value;
    } forwarded_t;

    forwarded_t w_forward;
    assign w_forward.addr        = r_wb_op.addr;
    assign w_forward.reg_status  = r_wb_op.reg_status;
    assign w_forward.valid       = r_wb_valid;
    assign w_forward.speculative = r_wb_op.speculative;
    assign w_forward.value       = r_wb_op.value;
    assign writeback_forward     = w_forward;
`endif

`ifndef SYNTHESIS
    a_no_result_when_empty: assert property (
        @(posedge clk) disable iff (!rst) mem_result_valid |-> (r_count != '0)
    );
`endif

endmodule
